// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Shared constants for the multicycle MIPS datapath. The register-destination
//   mux, the control FSM and the register bank all take the architectural
//   register indices from here, so $sp/$ra are defined in exactly one place.
//
//   Contents:
//     DEF_DATA_W    default datapath / register width
//     DEF_ADDR_W    default register index width
//     REG_ZERO      $zero index (hard-wired zero)
//     REG_SP        $sp index (non-zero reset value)
//     REG_RA        $ra index (link target)
//     SP_RESET_VAL  reset value of $sp
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;

    localparam int unsigned REG_ZERO     = 0;
    localparam int unsigned REG_SP       = 29;
    localparam int unsigned REG_RA       = 31;

    localparam int unsigned SP_RESET_VAL = 227;

endpackage : cpu_defs

// File: rtl/reg_en_ar.sv
// ---------------------------------------------------------------------------
// reg_en_ar
//   N-bit register with load enable and asynchronous active-low reset.
//   The reset value is a parameter so that one cell type covers both the
//   ordinary registers (reset to zero) and $sp (reset to a stack base).
//
//   Ports:
//     clk    in   1   rising-edge clock
//     rst_n  in   1   asynchronous, active-low reset -> q = RESET_VAL
//     en     in   1   load enable, sampled at rising clk edge
//     d      in   N   data to load
//     q      out  N   stored value
// ---------------------------------------------------------------------------
module reg_en_ar #(
    parameter int unsigned     N         = 32,
    parameter logic [N-1:0]    RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : reg_en_ar

// File: rtl/banco_reg_wb.sv
// ---------------------------------------------------------------------------
// banco_reg_wb
//   32 x 32-bit general-purpose register bank of the multicycle MIPS datapath.
//   Two combinational read ports feed the A/B operand latches; one synchronous
//   write port is driven in the write-back and link states. $zero is a
//   constant, $sp resets to a non-zero stack base.
//
//   Parameters:
//     DATA_W    register width in bits
//     ADDR_W    register index width (2**ADDR_W registers)
//     SP_IDX    index of the stack pointer register
//     SP_RESET  reset value of register SP_IDX
//     BYPASS    1: a read of the register being written this cycle returns
//               WriteData; 0: it returns the old contents
//
//   Ports:
//     clk        in   1       rising-edge clock
//     reset      in   1       asynchronous, active-low reset
//     RegWrite   in   1       write enable, sampled at rising clk edge
//     ReadReg1   in   ADDR_W  read port 1 index (instr[25:21])
//     ReadReg2   in   ADDR_W  read port 2 index (instr[20:16])
//     WriteReg   in   ADDR_W  write index, from register-destination mux
//     WriteData  in   DATA_W  write data, from memory-to-register mux
//     ReadData1  out  DATA_W  contents of ReadReg1
//     ReadData2  out  DATA_W  contents of ReadReg2
// ---------------------------------------------------------------------------
module banco_reg_wb
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned SP_IDX   = REG_SP,
    parameter int unsigned SP_RESET = SP_RESET_VAL,
    parameter bit          BYPASS   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int unsigned NREG = 1 << ADDR_W;

    // Register contents as seen by the read muxes; entry 0 is a constant.
    logic [DATA_W-1:0] regs [NREG];

    // One-hot write enables for the stored registers 1..NREG-1.
    logic [NREG-1:1]   we;

    // Write is effective only for a non-zero index with RegWrite high.
    logic              wr_live;

    assign wr_live = RegWrite && (WriteReg != ADDR_W'(REG_ZERO));

    // -----------------------------------------------------------------------
    // Write-enable decoder
    // -----------------------------------------------------------------------
    always_comb begin
        we = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            we[i] = RegWrite && (WriteReg == ADDR_W'(i));
        end
    end

    // -----------------------------------------------------------------------
    // Storage: index 0 is hard-wired, 1..NREG-1 are enable registers
    // -----------------------------------------------------------------------
    assign regs[0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_reg
        localparam logic [DATA_W-1:0] RST_VAL =
            (g == SP_IDX) ? DATA_W'(SP_RESET) : '0;

        reg_en_ar #(
            .N         (DATA_W),
            .RESET_VAL (RST_VAL)
        ) u_reg (
            .clk   (clk),
            .rst_n (reset),
            .en    (we[g]),
            .d     (WriteData),
            .q     (regs[g])
        );
    end

    // -----------------------------------------------------------------------
    // Read muxes with optional write-through bypass
    // -----------------------------------------------------------------------
    // The bypass is also gated by reset so that, while reset is held, both
    // ports show the reset contents rather than the pending write data.
    always_comb begin
        ReadData1 = regs[ReadReg1];
        if (BYPASS && reset && wr_live && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadReg2];
        if (BYPASS && reset && wr_live && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
        end
    end

endmodule : banco_reg_wb

// File: tb/tb_banco_reg_wb.sv
// ---------------------------------------------------------------------------
// tb_banco_reg_wb
//   Self-checking bench for banco_reg_wb. Two instances share all inputs:
//   u_nb with BYPASS=0 and u_bp with BYPASS=1. A bench-side register model
//   supplies expected values, which are queued when the read indices are
//   driven and popped once the combinational outputs have settled.
// ---------------------------------------------------------------------------
module tb_banco_reg_wb;
    import cpu_defs::*;

    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned NR = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWrite;
    logic [AW-1:0] ReadReg1;
    logic [AW-1:0] ReadReg2;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;

    always #5 clk = ~clk;

    banco_reg_wb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .SP_IDX   (REG_SP),
        .SP_RESET (SP_RESET_VAL),
        .BYPASS   (1'b0)
    ) u_nb (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (rd1_nb),
        .ReadData2 (rd2_nb)
    );

    banco_reg_wb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .SP_IDX   (REG_SP),
        .SP_RESET (SP_RESET_VAL),
        .BYPASS   (1'b1)
    ) u_bp (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadData1 (rd1_bp),
        .ReadData2 (rd2_bp)
    );

    typedef struct {
        string         tag;
        int unsigned   port;   // 0 nb.rd1, 1 nb.rd2, 2 bp.rd1, 3 bp.rd2
        logic [DW-1:0] exp;
    } sb_t;

    sb_t           sb [$];
    logic [DW-1:0] model [NR];
    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int unsigned i = 0; i < NR; i++) model[i] = '0;
        model[REG_SP] = DW'(SP_RESET_VAL);
    endtask

    // Expected value of a BYPASS=1 read of index r under the current inputs.
    function automatic logic [DW-1:0] bp_exp(input logic [AW-1:0] r);
        if (reset === 1'b1 && RegWrite === 1'b1 && WriteReg != '0 && WriteReg == r)
            return WriteData;
        return model[r];
    endfunction

    // Drive both read indices, queue expectations, let them settle, compare.
    task automatic read_check(input string tag, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        sb_t           e;
        logic [DW-1:0] got;
        ReadReg1 = r1;
        ReadReg2 = r2;
        sb.push_back('{tag: $sformatf("%s/nb1[%0d]", tag, r1), port: 0, exp: model[r1]});
        sb.push_back('{tag: $sformatf("%s/nb2[%0d]", tag, r2), port: 1, exp: model[r2]});
        sb.push_back('{tag: $sformatf("%s/bp1[%0d]", tag, r1), port: 2, exp: bp_exp(r1)});
        sb.push_back('{tag: $sformatf("%s/bp2[%0d]", tag, r2), port: 3, exp: bp_exp(r2)});
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                0:       got = rd1_nb;
                1:       got = rd2_nb;
                2:       got = rd1_bp;
                default: got = rd2_bp;
            endcase
            chk(e.tag, got, e.exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int unsigned i = 0; i < NR; i += 2)
            read_check(tag, AW'(i), AW'(i + 1));
    endtask

    // Inputs change on the falling edge, away from the sampling edge.
    task automatic drive_write(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd);
        @(negedge clk);
        RegWrite  = we;
        WriteReg  = wr;
        WriteData = wd;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
        if (reset === 1'b1 && RegWrite === 1'b1 && WriteReg != '0)
            model[WriteReg] = WriteData;
        RegWrite = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        model_reset();

        // 1: reset contents visible while reset is held and after release
        #2;
        sweep("rst_held");
        @(negedge clk);
        reset = 1'b1;
        sweep("rst_rel");

        // 2: ordinary write, then every other register unchanged
        drive_write(1'b1, 5'd8, 32'hDEADBEEF);
        clock_edge();
        sweep("wr8");

        // 3: writes to $zero are discarded
        drive_write(1'b1, 5'd0, 32'hFFFFFFFF);
        read_check("zero_pre", 5'd0, 5'd0);
        clock_edge();
        read_check("zero_post", 5'd0, 5'd0);

        // 4: same-cycle read of the write index ($ra)
        drive_write(1'b1, 5'd31, 32'h00000404);
        read_check("ra_same", 5'd8, 5'd31);
        clock_edge();
        read_check("ra_after", 5'd31, 5'd31);

        // 5: reset mid-cycle with a pending write, then write after release
        drive_write(1'b1, 5'd29, 32'd100);
        clock_edge();
        read_check("sp_wr", 5'd29, 5'd29);
        drive_write(1'b1, 5'd5, 32'd7);
        #2;
        reset = 1'b0;
        model_reset();
        read_check("midrst", 5'd29, 5'd5);
        @(posedge clk);
        #1;
        read_check("midrst_edge", 5'd29, 5'd5);
        #1;
        reset = 1'b1;
        read_check("rel_pend", 5'd5, 5'd29);
        clock_edge();
        read_check("rel_wr", 5'd29, 5'd5);

        // 6: RegWrite low holds the register across several edges
        drive_write(1'b1, 5'd12, 32'hA5A50012);
        clock_edge();
        for (int k = 0; k < 3; k++) begin
            drive_write(1'b0, 5'd12, 32'h12345678);
            read_check("hold_pre", 5'd12, 5'd12);
            clock_edge();
            read_check("hold_post", 5'd12, 5'd0);
        end

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            drive_write(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom));
            if (k % 3 == 0) ReadReg1 = WriteReg;
            read_check("rnd_pre", (k % 3 == 0) ? WriteReg : AW'($urandom_range(0, NR - 1)),
                       (k % 4 == 0) ? WriteReg : AW'($urandom_range(0, NR - 1)));
            clock_edge();
            read_check("rnd_post", AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
        end
        sweep("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_banco_reg_wb
